// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared encodings and default parameters for the hazard scoreboard
package hazard_pkg;

  localparam int NREGS_DEF   = 16;
  localparam int AW_DEF      = 4;
  localparam int MAX_LAT_DEF = 15;
  localparam int CW_DEF      = 4;
  localparam int FWD_EN_DEF  = 1;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

endpackage

// File: rtl/sb_counter.sv
// rtl/sb_counter.sv - per-register long-op countdown; done is asserted in the write-back cycle
module sb_counter #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] loadVal,
  output logic          busy,
  output logic          done
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= loadVal;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign busy = (cnt != '0);
  assign done = (cnt == CW'(1));

endmodule

// File: rtl/hazard_sb.sv
// rtl/hazard_sb.sv - pipeline hazard unit with forwarding, load-use stall and long-op scoreboard
module hazard_sb
  import hazard_pkg::*;
#(
  parameter int NREGS   = NREGS_DEF,
  parameter int AW      = AW_DEF,
  parameter int MAX_LAT = MAX_LAT_DEF,
  parameter int CW      = CW_DEF,
  parameter int FWD_EN  = FWD_EN_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    RA1D,
  input  logic [AW-1:0]    RA2D,
  input  logic             UseA1D,
  input  logic             UseA2D,
  input  logic [AW-1:0]    WA3D,
  input  logic             RegWriteD,
  input  logic             LongD,
  input  logic [CW-1:0]    LatD,
  input  logic [AW-1:0]    RA1E,
  input  logic [AW-1:0]    RA2E,
  input  logic [AW-1:0]    WA3E,
  input  logic             RegWriteE,
  input  logic             MemtoRegE,
  input  logic [AW-1:0]    WA3M,
  input  logic             RegWriteM,
  input  logic [AW-1:0]    WA3W,
  input  logic             RegWriteW,
  input  logic             PCSrcD,
  input  logic             PCSrcE,
  input  logic             PCSrcM,
  input  logic             PCSrcW,
  input  logic             BranchTakenE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic             LongIssue,
  output logic [NREGS-1:0] LongDone,
  output logic [AW:0]      LongPending
);

  logic [NREGS-1:0] busy;
  logic [CW-1:0]    latEff;
  logic             ldstall, sbstall, nfstall, dstall, brpend;

  // Zero latency means one cycle; anything beyond the unit's worst case is clamped.
  always_comb begin
    latEff = LatD;
    if (LatD == '0) latEff = CW'(1);
    else if (LatD > CW'(MAX_LAT)) latEff = CW'(MAX_LAT);
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_sb
    sb_counter #(.CW(CW)) u_cnt (
      .clk     (clk),
      .reset   (reset),
      .load    (LongIssue && (WA3D == AW'(g))),
      .loadVal (latEff),
      .busy    (busy[g]),
      .done    (LongDone[g])
    );
  end

  always_comb begin
    ldstall = MemtoRegE && RegWriteE &&
              ((UseA1D && (RA1D == WA3E)) || (UseA2D && (RA2D == WA3E)));
    sbstall = (UseA1D && busy[RA1D]) || (UseA2D && busy[RA2D]) ||
              (RegWriteD && busy[WA3D]);
    nfstall = 1'b0;
    // Without forwarding, only E and M producers matter: W writes the regfile first half-cycle.
    if (FWD_EN == 0) begin
      nfstall = (UseA1D && ((RegWriteE && (RA1D == WA3E)) || (RegWriteM && (RA1D == WA3M)))) ||
                (UseA2D && ((RegWriteE && (RA2D == WA3E)) || (RegWriteM && (RA2D == WA3M))));
    end
    dstall = ldstall || sbstall || nfstall;
    brpend = PCSrcD || PCSrcE || PCSrcM;
  end

  assign StallD    = dstall;
  assign StallF    = dstall | brpend;
  assign FlushD    = brpend | PCSrcW | BranchTakenE;
  assign FlushE    = dstall | BranchTakenE;
  assign LongIssue = reset & LongD & RegWriteD & ~StallD & ~FlushE;

  always_comb begin
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    if (FWD_EN != 0) begin
      if (RegWriteM && (RA1E == WA3M))      ForwardAE = FWD_M;
      else if (RegWriteW && (RA1E == WA3W)) ForwardAE = FWD_W;
      if (RegWriteM && (RA2E == WA3M))      ForwardBE = FWD_M;
      else if (RegWriteW && (RA2E == WA3W)) ForwardBE = FWD_W;
    end
  end

  always_comb begin
    LongPending = '0;
    for (int i = 0; i < NREGS; i++) LongPending = LongPending + (AW+1)'(busy[i]);
  end

endmodule

// File: tb/tb_hazard_sb.sv
// tb/tb_hazard_sb.sv - directed-vector bench for hazard_sb in forwarding and stall-only modes
module tb_hazard_sb;

  logic        clk, reset;
  logic [3:0]  RA1D, RA2D, WA3D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic        UseA1D, UseA2D, RegWriteD, LongD;
  logic [3:0]  LatD;
  logic        RegWriteE, MemtoRegE, RegWriteM, RegWriteW;
  logic        PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE;

  logic [1:0]  ForwardAE, ForwardBE, fwdAE0, fwdBE0;
  logic        StallF, StallD, FlushD, FlushE, LongIssue;
  logic        stallF0, stallD0, flushD0, flushE0, longIssue0;
  logic [15:0] LongDone, longDone0;
  logic [4:0]  LongPending, longPending0;

  int nVec = 0;
  int nErr = 0;

  hazard_sb #(.FWD_EN(1)) dut (
    .clk(clk), .reset(reset), .RA1D(RA1D), .RA2D(RA2D), .UseA1D(UseA1D), .UseA2D(UseA2D),
    .WA3D(WA3D), .RegWriteD(RegWriteD), .LongD(LongD), .LatD(LatD), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .WA3M(WA3M), .RegWriteM(RegWriteM),
    .WA3W(WA3W), .RegWriteW(RegWriteW), .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM),
    .PCSrcW(PCSrcW), .BranchTakenE(BranchTakenE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE), .LongIssue(LongIssue),
    .LongDone(LongDone), .LongPending(LongPending)
  );

  hazard_sb #(.FWD_EN(0)) dutNf (
    .clk(clk), .reset(reset), .RA1D(RA1D), .RA2D(RA2D), .UseA1D(UseA1D), .UseA2D(UseA2D),
    .WA3D(WA3D), .RegWriteD(RegWriteD), .LongD(LongD), .LatD(LatD), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .WA3M(WA3M), .RegWriteM(RegWriteM),
    .WA3W(WA3W), .RegWriteW(RegWriteW), .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM),
    .PCSrcW(PCSrcW), .BranchTakenE(BranchTakenE), .ForwardAE(fwdAE0), .ForwardBE(fwdBE0),
    .StallF(stallF0), .StallD(stallD0), .FlushD(flushD0), .FlushE(flushE0), .LongIssue(longIssue0),
    .LongDone(longDone0), .LongPending(longPending0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVec++;
    if (obs !== exp) begin
      nErr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    {RA1D, RA2D, WA3D, RA1E, RA2E, WA3E, WA3M, WA3W, LatD} = '0;
    {UseA1D, UseA2D, RegWriteD, LongD, RegWriteE, MemtoRegE, RegWriteM, RegWriteW} = '0;
    {PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE} = '0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    clr();
    reset = 1'b0;
    // Reset held with an issuable long op present
    LongD = 1; RegWriteD = 1; WA3D = 7; LatD = 4;
    cyc(2); settle();
    check("rst_issue", LongIssue, 0);
    check("rst_pend", LongPending, 0);
    check("rst_done", LongDone, 0);
    check("rst_fwdA", ForwardAE, 0);
    check("rst_stallD", StallD, 0);
    check("rst_nf_pend", longPending0, 0);

    // Release and issue R7, latency 4
    reset = 1'b1; settle();
    check("issue7", LongIssue, 1);
    cyc(1);
    LongD = 0; RegWriteD = 0; UseA1D = 1; RA1D = 7; settle();
    check("lat4_pend", LongPending, 1);
    check("lat4_stall_c1", StallD, 1);
    check("lat4_done_c1", LongDone, 0);
    cyc(1); settle();
    check("lat4_done_c2", LongDone, 0);
    check("lat4_stall_c2", StallD, 1);
    cyc(1); settle();
    check("lat4_done_c3", LongDone, 0);
    cyc(1); settle();
    check("lat4_done_c4", LongDone, 16'h0080);
    check("lat4_stall_c4", StallD, 1);
    cyc(1); settle();
    check("lat4_done_after", LongDone, 0);
    check("lat4_stall_after", StallD, 0);
    check("lat4_pend_after", LongPending, 0);

    // Zero latency behaves as one cycle
    clr(); LongD = 1; RegWriteD = 1; WA3D = 5; LatD = 0; settle();
    check("lat0_issue", LongIssue, 1);
    cyc(1); LongD = 0; RegWriteD = 0; settle();
    check("lat0_done", LongDone, 16'h0020);
    check("lat0_pend", LongPending, 1);
    cyc(1); settle();
    check("lat0_free", LongPending, 0);

    // Back-to-back issues completing together, plus WAW on R2
    clr(); LongD = 1; RegWriteD = 1; WA3D = 2; LatD = 3; settle();
    check("cc_issue2", LongIssue, 1);
    cyc(1); WA3D = 4; LatD = 2; settle();
    check("cc_issue4", LongIssue, 1);
    cyc(1); LongD = 0; WA3D = 2; settle();
    check("cc_pend2", LongPending, 2);
    check("cc_waw_stall", StallD, 1);
    check("cc_waw_flushE", FlushE, 1);
    cyc(1); settle();
    check("cc_done", LongDone, 16'h0014);
    check("cc_waw_stall_done", StallD, 1);
    cyc(1); settle();
    check("cc_done_clr", LongDone, 0);
    check("cc_waw_free", StallD, 0);

    // Forwarding priority
    clr(); RA1E = 3; WA3M = 3; WA3W = 3; RegWriteM = 1; RegWriteW = 1; settle();
    check("fwdA_M", ForwardAE, 2'b10);
    check("fwdB_none", ForwardBE, 2'b00);
    check("nf_fwdA", fwdAE0, 2'b00);
    RegWriteM = 0; RA2E = 3; settle();
    check("fwdA_W", ForwardAE, 2'b01);
    check("fwdB_W", ForwardBE, 2'b01);
    RA1E = 4; settle();
    check("fwdA_rf", ForwardAE, 2'b00);
    // Stall-only mode
    clr(); RA1D = 3; UseA1D = 1; WA3E = 3; RegWriteE = 1; settle();
    check("nf_stallE", stallD0, 1);
    check("nf_flushE", flushE0, 1);
    check("fw_nostall", StallD, 0);
    RegWriteE = 0; WA3M = 3; RegWriteM = 1; settle();
    check("nf_stallM", stallD0, 1);
    RegWriteM = 0; WA3W = 3; RegWriteW = 1; settle();
    check("nf_noW", stallD0, 0);

    // Load-use
    clr(); MemtoRegE = 1; RegWriteE = 1; WA3E = 5; RA2D = 5; UseA2D = 1; settle();
    check("lu_stallF", StallF, 1);
    check("lu_stallD", StallD, 1);
    check("lu_flushE", FlushE, 1);
    cyc(1); MemtoRegE = 0; RegWriteE = 0; settle();
    check("lu_release", StallD, 0);
    MemtoRegE = 1; RegWriteE = 1; UseA2D = 0; settle();
    check("lu_unused", StallD, 0);

    // Taken branch suppresses issue
    clr(); LongD = 1; RegWriteD = 1; WA3D = 6; LatD = 2; BranchTakenE = 1; settle();
    check("br_issue", LongIssue, 0);
    check("br_flushD", FlushD, 1);
    check("br_flushE", FlushE, 1);
    cyc(1); settle();
    check("br_pend", LongPending, 0);
    clr(); PCSrcE = 1; settle();
    check("pce_stallF", StallF, 1);
    check("pce_flushD", FlushD, 1);
    check("pce_stallD", StallD, 0);
    clr(); PCSrcW = 1; settle();
    check("pcw_flushD", FlushD, 1);
    check("pcw_stallF", StallF, 0);

    // Reset while R9 is in flight
    clr(); LongD = 1; RegWriteD = 1; WA3D = 9; LatD = 5; settle();
    cyc(1); LongD = 0; RegWriteD = 0; settle();
    check("mr_pend_before", LongPending, 1);
    reset = 1'b0; settle();
    check("mr_pend_rst", LongPending, 0);
    check("mr_done_rst", LongDone, 0);
    cyc(1); reset = 1'b1; settle();
    for (int i = 0; i < 6; i++) begin
      check("mr_no_done", LongDone, 0);
      cyc(1); settle();
    end
    check("mr_pend_end", LongPending, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule

// File: doc/hazard_sb.md
Name: hazard_sb

Overview:
- Parametrised next-generation hazard unit for the 5-stage pipelined ARM core.
- Adds a per-register scoreboard for a variable-latency long-op unit (multiply/divide), which writes back through its own register-file port.
- Selectable forwarding mode: forwarding on, or stall-only.
- Sits beside controller/datapath; consumes the stage register addresses and write enables, and drives forward selects and the stall/flush controls.

Parameters:
- NREGS, 16, architectural registers tracked (power of 2).
- AW, 4, register address width (= log2 NREGS).
- MAX_LAT, 15, largest long-op latency in cycles.
- CW, 4, counter width (must satisfy 2^CW > MAX_LAT).
- FWD_EN, 1, 1 = E-stage forwarding from M/W; 0 = stall-only mode.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low (0 = reset)
- RA1D, RA2D  in  AW  decode source registers
- UseA1D, UseA2D  in  1  source actually read in D
- WA3D  in  AW  decode destination register
- RegWriteD  in  1  decode instruction writes WA3D
- LongD  in  1  decode instruction goes to the long-op unit
- LatD  in  CW  long-op latency; 0 is treated as 1
- RA1E, RA2E  in  AW  execute source registers
- WA3E  in  AW  execute destination register
- RegWriteE, MemtoRegE  in  1  execute-stage controls
- WA3M, RegWriteM  in  AW, 1  memory-stage destination and write enable
- WA3W, RegWriteW  in  AW, 1  writeback-stage destination and write enable
- PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE  in  1  control-flow events
- ForwardAE, ForwardBE  out  2  00 = regfile, 01 = W result, 10 = M ALU result
- StallF, StallD, FlushD, FlushE  out  1  pipeline controls
- LongIssue  out  1  long op accepted this cycle
- LongDone  out  NREGS  one-hot per register: long result written this cycle
- LongPending  out  AW+1  number of busy registers

Behaviour:
- State: cnt[r] (CW bits) per register; busy[r] = (cnt[r] != 0). Everything else is combinational from inputs and cnt.
- Reset (async, reset==0): all cnt = 0.
  - Outputs during reset are therefore Forward* = 00, LongDone = 0, LongPending = 0, LongIssue = 0.
  - Stall/flush follow their combinational equations with busy = 0.
  - Reset mid-operation discards all in-flight long ops; no LongDone pulse is issued for them.
- ldstall = MemtoRegE & RegWriteE & ((UseA1D & RA1D==WA3E) | (UseA2D & RA2D==WA3E)).
- sbstall = (UseA1D & busy[RA1D]) | (UseA2D & busy[RA2D]) | (RegWriteD & busy[WA3D]). The WA3D term is the WAW check.
- nfstall:
  - FWD_EN=1: nfstall = 0.
  - FWD_EN=0: nfstall = 1 when a used D source equals WA3E (with RegWriteE) or WA3M (with RegWriteM). W is not checked; the regfile writes in the first half-cycle.
- dstall = ldstall | sbstall | nfstall.
- brpend = PCSrcD | PCSrcE | PCSrcM.
- Stall/flush equations:
  - StallD = dstall.
  - StallF = dstall | brpend.
  - FlushD = brpend | PCSrcW | BranchTakenE.
  - FlushE = dstall | BranchTakenE.
- Forwarding:
  - FWD_EN=1, A operand: ForwardAE = 10 if RegWriteM & RA1E==WA3M; else 01 if RegWriteW & RA1E==WA3W; else 00. M has priority over W.
  - B operand: same rule for ForwardBE using RA2E.
  - FWD_EN=0: both selects are constant 00.
- Issue:
  - LongIssue = LongD & RegWriteD & ~StallD & ~FlushE.
  - On LongIssue, cnt[WA3D] <= max(LatD,1) at the next edge. WAW stalling guarantees that register was idle.
- Countdown:
  - Each cycle, every nonzero cnt[r] decrements by 1.
  - LongDone[r] = (cnt[r]==1), combinational. Several bits may be set in the same cycle.
  - A register is free, and its readers unstall, in the cycle after LongDone.
- Simultaneous events:
  - Issue to register r in the same cycle r completes is impossible, since WAW stalls while cnt[r]==1.
  - An issue in the same cycle as another register's decrement is independent.
  - BranchTakenE suppresses issue of the D instruction.
- LongPending = popcount(busy). Range 0..NREGS.

Decomposition:
- Shared package hazard_pkg holds the forward-select encodings (FWD_RF=00, FWD_W=01, FWD_M=10) and the default parameter values.
- One sub-module: sb_counter, a single-register CW-bit countdown with load and done output, instantiated NREGS times by generate.
- The stall/forward logic stays in the top level.

Test Plan:
- Reset: hold reset=0 with LongD=1 and the issue conditions met -> cnt stays 0, LongPending=0, LongDone=0. After release, the first issue is accepted.
- Forward priority: RA1E=3, WA3M=3, WA3W=3, both RegWrite=1 -> ForwardAE=10. Drop RegWriteM -> ForwardAE=01. With FWD_EN=0 and RA1D=3, WA3E=3, RegWriteE=1 -> StallD=1 and FlushE=1.
- Load-use: MemtoRegE=1, WA3E=5, RA2D=5, UseA2D=1 -> StallF=StallD=FlushE=1 for exactly one cycle.
- Long op: issue with WA3D=7, LatD=4 -> LongPending=1. LongDone[7] pulses 4 cycles after the issue edge. A consumer with RA1D=7 stalls until the cycle after the pulse. LatD=0 completes after 1 cycle.
- Concurrent completion: issue R2 (LatD=3), then next cycle R4 (LatD=2) -> LongDone = 0x0014 in a single cycle. WAW on R2 during flight -> StallD=1.
- Branch and mid-op reset: BranchTakenE=1 with LongD=1 -> LongIssue=0, FlushD=FlushE=1. Assert reset while R9 is busy -> LongPending=0 immediately and no LongDone[9] pulse.
